// File: rtl/memunit_pkg.sv
// Shared types for the cached memory unit: FSM states and load/store size encodings.
package memunit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_e;

  localparam logic [2:0] MC_B  = 3'b000;
  localparam logic [2:0] MC_H  = 3'b001;
  localparam logic [2:0] MC_W  = 3'b010;
  localparam logic [2:0] MC_BU = 3'b100;
  localparam logic [2:0] MC_HU = 3'b101;
endpackage

// File: rtl/cached_memoryunit_if.sv
// Line-granular backing-memory bus between the cache (master) and memory (slave).
interface cached_memoryunit_if #(
  parameter int LADDR_W = 28,
  parameter int LINE_W  = 128
);
  logic               mem_req;
  logic               mem_we;
  logic [LADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;
  logic               mem_ready;
  logic [LINE_W-1:0]  mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte/half/word lane selection: extends loads and merges stores into the addressed word.
module lsu_align import memunit_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            lane_i,
  input  logic [2:0]            ctrl_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic [DATA_WIDTH-1:0] st_word_o
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[{lane_i, 3'b000} +: 8];
    // half lane is address[1] only, so an odd half address wraps within the word
    h = word_i[{lane_i[1], 4'b0000} +: 16];
    case (ctrl_i)
      MC_B:    ld_data_o = {{(DATA_WIDTH-8){b[7]}}, b};
      MC_BU:   ld_data_o = {{(DATA_WIDTH-8){1'b0}}, b};
      MC_H:    ld_data_o = {{(DATA_WIDTH-16){h[15]}}, h};
      MC_HU:   ld_data_o = {{(DATA_WIDTH-16){1'b0}}, h};
      default: ld_data_o = word_i;
    endcase
    st_word_o = word_i;
    case (ctrl_i[1:0])
      2'b00:   st_word_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'b01:   st_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: st_word_o = wdata_i;
    endcase
  end
endmodule

// File: rtl/cached_memoryunit.sv
// Write-back, write-allocate set-associative data cache with one LRU bit per set.
module cached_memoryunit import memunit_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SET_BITS      = 3,
  parameter int BLOCK_SIZE    = 2,
  parameter int WAYS          = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [2:0]               DATAMEMControl,
  input  logic                     write_enable,
  input  logic                     read_en,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     stall,
  cached_memoryunit_if.master      mem,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);
  localparam int LINE_W  = DATA_WIDTH * (2**BLOCK_SIZE);
  localparam int SETS    = 2**SET_BITS;
  localparam int LADDR_W = ADDRESS_WIDTH - 2 - BLOCK_SIZE;
  localparam int TAG_W   = LADDR_W - SET_BITS;

  logic [LINE_W-1:0]          data_q [WAYS][SETS];
  logic [LINE_W-1:0]          data_d [WAYS][SETS];
  logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
  logic [TAG_W-1:0]           tag_d  [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0]            lru_q, lru_d;
  state_e                     state_q, state_d;
  logic [31:0]                hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                       refilled_q, refilled_d;

  logic [BLOCK_SIZE-1:0]      word_off;
  logic [SET_BITS-1:0]        set_idx;
  logic [TAG_W-1:0]           tag;
  logic                       hit, hit_way, victim, access, idle;
  logic                       mem_req_c, mem_we_c;
  logic [DATA_WIDTH-1:0]      cur_word, ld_data, st_word;

  assign word_off = address[2 +: BLOCK_SIZE];
  assign set_idx  = address[2+BLOCK_SIZE +: SET_BITS];
  assign tag      = address[ADDRESS_WIDTH-1 -: TAG_W];
  assign access   = write_enable | read_en;
  assign idle     = (state_q == S_IDLE);
  // lru bit names the way to evict next
  assign victim   = (WAYS == 2) ? lru_q[set_idx] : 1'b0;

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w][set_idx] && tag_q[w][set_idx] == tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
  end

  assign cur_word = data_q[hit_way][set_idx][int'(word_off)*DATA_WIDTH +: DATA_WIDTH];

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word_i(cur_word), .lane_i(address[1:0]), .ctrl_i(DATAMEMControl),
    .wdata_i(write_data), .ld_data_o(ld_data), .st_word_o(st_word)
  );

  assign read_data     = read_en ? ld_data : '0;
  assign mem.mem_req   = mem_req_c;
  assign mem.mem_we    = mem_we_c;
  assign mem.mem_addr  = (state_q == S_WRITEBACK) ? {tag_q[victim][set_idx], set_idx} : {tag, set_idx};
  assign mem.mem_wdata = data_q[victim][set_idx];
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refilled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      refilled_q <= refilled_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (access && !hit)
                     state_d = (valid_q[victim][set_idx] && dirty_q[victim][set_idx]) ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (mem.mem_ready) state_d = S_REFILL;
      S_REFILL:    if (mem.mem_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    case (state_q)
      S_IDLE:      stall = access & ~hit;
      S_WRITEBACK: begin stall = 1'b1; mem_req_c = 1'b1; mem_we_c = 1'b1; end
      S_REFILL:    begin stall = 1'b1; mem_req_c = 1'b1; end
      default:     stall = 1'b1;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    refilled_d = idle ? 1'b0 : refilled_q;
    if (idle && access) begin
      if (hit) begin
        lru_d[set_idx] = ~hit_way;
        // the first hit after a refill completes an access already counted as a miss
        if (!refilled_q) hit_cnt_d = hit_cnt_q + 32'd1;
        if (write_enable) begin
          data_d[hit_way][set_idx][int'(word_off)*DATA_WIDTH +: DATA_WIDTH] = st_word;
          dirty_d[hit_way][set_idx] = 1'b1;
        end
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
    if (state_q == S_REFILL && mem.mem_ready) begin
      data_d[victim][set_idx]  = mem.mem_rdata;
      tag_d[victim][set_idx]   = tag;
      valid_d[victim][set_idx] = 1'b1;
      dirty_d[victim][set_idx] = 1'b0;
      lru_d[set_idx]           = ~victim;
      refilled_d               = 1'b1;
    end
  end
endmodule

// File: tb/tb_cached_memoryunit.sv
// Scoreboard bench: stimulus queues expected loads/write-backs, monitors pop and compare.
module tb_cached_memoryunit;
  import memunit_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data, hit_count, miss_count;
  logic [2:0]  DATAMEMControl = MC_W;
  logic        write_enable = 1'b0, read_en = 1'b0, stall;

  cached_memoryunit_if #(.LADDR_W(28), .LINE_W(128)) mif ();

  cached_memoryunit dut (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
    .DATAMEMControl(DATAMEMControl), .write_enable(write_enable), .read_en(read_en),
    .read_data(read_data), .stall(stall), .mem(mif), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] val; } ld_t;
  typedef struct { logic [27:0] addr; logic [127:0] data; } wb_t;

  int          errors = 0, checks = 0;
  ld_t         ld_q[$];
  wb_t         wb_q[$];
  logic [127:0] bmem [logic [27:0]];
  int          mem_delay = 0, wait_cnt = 0;
  logic        first_req, first_we;
  wb_t         wb_e;
  ld_t         ld_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // backing memory: answers each request after mem_delay wait cycles
  always @(negedge clk) begin
    mif.mem_ready = 1'b0;
    if (mif.mem_req) begin
      if (wait_cnt >= mem_delay) begin
        wait_cnt = 0;
        mif.mem_ready = 1'b1;
        if (mif.mem_we) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got addr %0h, none expected", mif.mem_addr);
          end else begin
            wb_e = wb_q.pop_front();
            chk("wb_addr", 128'(mif.mem_addr), 128'(wb_e.addr));
            chk("wb_data", mif.mem_wdata, wb_e.data);
          end
          bmem[mif.mem_addr] = mif.mem_wdata;
        end else begin
          mif.mem_rdata = bmem.exists(mif.mem_addr) ? bmem[mif.mem_addr] : '0;
        end
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // load monitor: a completed load is a non-stalled cycle with read_en
  always @(negedge clk) begin
    if (rst_n && read_en && !write_enable && !stall) begin
      if (ld_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL load_unexpected: got %0h, none expected", read_data);
      end else begin
        ld_e = ld_q.pop_front();
        chk(ld_e.name, 128'(read_data), 128'(ld_e.val));
      end
    end
  end

  task automatic access(input string nm, input logic we, input logic re, input logic [2:0] ctl,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_stalls);
    int  n = 0;
    bit  done = 0;
    address = a; write_data = wd; DATAMEMControl = ctl; write_enable = we; read_en = re;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin first_req = mif.mem_req; first_we = mif.mem_we; end
      if (stall) n++; else done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, required completion", nm, n);
    end
    chk({nm, "_stalls"}, 128'(n), 128'(exp_stalls));
    @(posedge clk); #1;
    write_enable = 1'b0; read_en = 1'b0;
  endtask

  task automatic load(input string nm, input logic [2:0] ctl, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_stalls);
    ld_q.push_back('{nm, exp});
    access(nm, 1'b0, 1'b1, ctl, a, 32'h0, exp_stalls);
  endtask

  initial begin
    bmem[28'h10] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h8001_0000};
    bmem[28'h20] = {32'h2020_0003, 32'h2020_0002, 32'h2020_0001, 32'h2020_0000};
    bmem[28'h30] = {32'h3030_0003, 32'h3030_0002, 32'h3030_0001, 32'h3030_0000};
    bmem[28'h05] = {32'h0505_0003, 32'h0505_0002, 32'h0505_0001, 32'h0505_0505};
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_mem_req", 128'(mif.mem_req), 128'(0));
    chk("rst_mem_we", 128'(mif.mem_we), 128'(0));
    chk("rst_hits", 128'(hit_count), 128'(0));
    chk("rst_misses", 128'(miss_count), 128'(0));
    @(posedge clk); #1;

    load("lw_cold", MC_W, 32'h100, 32'h8001_0000, 2);
    chk("cold_first_req", 128'(first_req), 128'(0));
    chk("cold_first_we", 128'(first_we), 128'(0));
    chk("cold_misses", 128'(miss_count), 128'(1));
    chk("cold_hits", 128'(hit_count), 128'(0));

    access("sb_101", 1'b1, 1'b0, MC_B, 32'h101, 32'h0000_00AB, 0);
    load("lbu_101", MC_BU, 32'h101, 32'h0000_00AB, 0);
    chk("hits_after_lbu", 128'(hit_count), 128'(2));
    load("lb_101",  MC_B,  32'h101, 32'hFFFF_FFAB, 0);
    load("lh_102",  MC_H,  32'h102, 32'hFFFF_8001, 0);
    load("lhu_102", MC_HU, 32'h102, 32'h0000_8001, 0);
    load("lh_101_wrap", MC_H, 32'h101, 32'hFFFF_AB00, 0);
    load("lb_103",  MC_B,  32'h103, 32'hFFFF_FF80, 0);
    load("lw_100",  MC_W,  32'h100, 32'h8001_AB00, 0);
    chk("hits_set0", 128'(hit_count), 128'(8));
    chk("misses_set0", 128'(miss_count), 128'(1));

    repeat (3) @(posedge clk); #1;
    chk("idle_stall", 128'(stall), 128'(0));
    chk("idle_hits", 128'(hit_count), 128'(8));

    load("lw_200", MC_W, 32'h200, 32'h2020_0000, 2);
    access("sw_200", 1'b1, 1'b0, MC_W, 32'h200, 32'hDEAD_BEEF, 0);
    chk("misses_way1", 128'(miss_count), 128'(2));

    mem_delay = 5;
    wb_q.push_back('{28'h10, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h8001_AB00}});
    load("lw_304_wb", MC_W, 32'h304, 32'h3030_0001, 13);
    mem_delay = 0;
    wb_q.push_back('{28'h20, {32'h2020_0003, 32'h2020_0002, 32'h2020_0001, 32'hDEAD_BEEF}});
    load("lw_100_wb", MC_W, 32'h100, 32'h8001_AB00, 3);
    chk("misses_wb", 128'(miss_count), 128'(4));
    chk("hits_wb", 128'(hit_count), 128'(9));
    chk("wb_q_drained", 128'(wb_q.size()), 128'(0));

    mem_delay = 100;
    address = 32'h050; DATAMEMControl = MC_W; read_en = 1'b1;
    @(negedge clk);
    chk("rr_miss_stall", 128'(stall), 128'(1));
    @(negedge clk);
    chk("rr_refill_req", 128'(mif.mem_req), 128'(1));
    chk("rr_refill_we", 128'(mif.mem_we), 128'(0));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rr_req_dropped", 128'(mif.mem_req), 128'(0));
    chk("rr_misses_clr", 128'(miss_count), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; read_en = 1'b0; mem_delay = 0;
    @(negedge clk);
    chk("rr_idle_req", 128'(mif.mem_req), 128'(0));
    @(posedge clk); #1;
    load("lw_050_again", MC_W, 32'h050, 32'h0505_0505, 2);
    load("lw_100_after_rst", MC_W, 32'h100, 32'h8001_AB00, 2);
    chk("rr_misses", 128'(miss_count), 128'(2));
    chk("rr_hits", 128'(hit_count), 128'(0));
    chk("ld_q_drained", 128'(ld_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cached_memoryunit.md
CACHED_MEMORYUNIT -- requirements
Module: cached_memoryunit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter SET_BITS, default 3, log2 of set count.
REQ-004 SHALL have parameter BLOCK_SIZE, default 2, log2 of words per line.
REQ-005 SHALL have parameter WAYS, default 2, legal values 1 or 2.
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 address  input  ADDRESS_WIDTH  byte address of the CPU access.
REQ-010 write_data  input  DATA_WIDTH  store data, right-aligned.
REQ-011 DATAMEMControl  input  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-012 write_enable  input  1  store request.
REQ-013 read_en  input  1  load request.
REQ-014 read_data  output  DATA_WIDTH  extended load result.
REQ-015 stall  output  1  access not complete; CPU holds all inputs stable.
REQ-016 mem_req  output  1  backing-memory request valid.
REQ-017 mem_we  output  1  request is a line write-back.
REQ-018 mem_addr  output  ADDRESS_WIDTH-2-BLOCK_SIZE  line address.
REQ-019 mem_wdata  output  DATA_WIDTH*2**BLOCK_SIZE  victim line data.
REQ-020 mem_ready  input  1  backing memory accepts/completes the current request.
REQ-021 mem_rdata  input  DATA_WIDTH*2**BLOCK_SIZE  refill line, valid with mem_ready.
REQ-022 hit_count, miss_count  output  32 each  performance counters.

Function
REQ-023 SHALL implement a write-back, write-allocate, WAYS-way set-associative cache with per-line valid, dirty and tag bits, and one LRU bit per set.
REQ-024 On a hit in IDLE: stall=0; read_data is valid combinationally in the same cycle; a store merges its byte/half/word into the line at the clock edge, sets dirty and updates LRU.
REQ-025 Byte lane = address[1:0]; half lane = address[1]; misaligned halves SHALL wrap within the word, with no trap.
REQ-026 Loads SHALL sign-extend or zero-extend per DATAMEMControl; read_data = 0 when read_en=0.
REQ-027 write_enable SHALL take priority when read_en and write_enable are both 1; with neither asserted, stall=0 and no state changes.
REQ-028 FSM states SHALL be IDLE, WRITEBACK and REFILL.
REQ-029 Miss in IDLE: stall=1 in that same cycle; next state is WRITEBACK if the LRU victim is valid and dirty, else REFILL.
REQ-030 WRITEBACK: mem_req=1, mem_we=1, victim address and data held until mem_ready, then REFILL.
REQ-031 REFILL: mem_req=1, mem_we=0 until mem_ready; install mem_rdata with valid=1, dirty=0 and the new tag; return to IDLE.
REQ-032 The held access SHALL re-evaluate as a hit in the following IDLE cycle; miss-to-completion latency is 2 cycles plus memory wait cycles, or 3 cycles plus waits with a write-back.
REQ-033 hit_count SHALL increment once per completed hit access, and miss_count once per miss detection; both wrap modulo 2^32.
REQ-034 A held access that turns into a hit after refill SHALL count as a miss only.
REQ-035 stall=1 in every non-IDLE state.

Reset
REQ-036 While rst_n=0 at a clock edge: state=IDLE, all valid/dirty/LRU bits=0, and both counters=0.
REQ-037 Outputs after reset: stall=0 unless a miss is presented; mem_req=0; mem_we=0.
REQ-038 Reset mid-WRITEBACK/REFILL SHALL abandon the transaction, with mem_req=0 from the next cycle; line data need not be cleared.

Structure
REQ-039 Package memunit_pkg SHALL hold the FSM state enum and the DATAMEMControl encodings.
REQ-040 Combinational load/store lane alignment SHALL be in sub-module lsu_align.

Verification
REQ-041 Reset, then LW 0x100 (cold): stall=1, mem_req/mem_we=0/0, line 0x10 refilled after mem_ready; then read_data=mem word; miss_count=1.
REQ-042 SB 0xAB to 0x101 after the REQ-041 refill: no stall; following LBU 0x101 = 0x000000AB and LB 0x101 = 0xFFFFFFAB; hit_count=2.
REQ-043 Fill both ways of set 0 (dirty), then a third tag to set 0: WRITEBACK of the LRU line with the merged data, then REFILL; mem_ready delayed 5 cycles keeps stall=1 throughout.
REQ-044 LH at 0x102 of word 0x8001_0000: read_data=0xFFFF8001; LHU gives 0x00008001.
REQ-045 Assert rst_n=0 during REFILL: mem_req=0 next cycle; re-access of the same address misses again.
